// File: rtl/cnna_sram_sched_pkg.sv
// Shared types and default widths for the activation/weight SRAM ownership scheduler.
// Latency: n/a (types only). Backpressure: n/a.
// Optional denied-request statistics are enabled in the top by CNNA_SRAM_SCHED_STATS_EN.
package cnna_sram_sched_pkg;

    localparam int          ADDR_W_DEF     = 8;
    localparam int          UDP_WR_W_DEF   = 128;
    localparam int          WIDE_W_DEF     = 512;
    localparam int          CNNA_RD_W_DEF  = 128;
    localparam logic [31:0] TIMEOUT_DEF    = 32'd1000000;

    typedef enum logic [1:0] {
        UDP_OWN,
        LAUNCH,
        CNNA_RUN,
        DONE
    } sched_state_t;

    typedef enum logic {
        OWN_UDP,
        OWN_CNNA
    } owner_t;

endpackage

// File: rtl/cnna_run_timer.sv
// Saturating 32-bit run-length counter with watchdog compare against TIMEOUT_CYCLES-1.
// Latency: count updates one cycle after en; expire is combinational from count.
// Backpressure: none; clear has priority over en.
module cnna_run_timer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        clear,
    input  logic        en,
    output logic [31:0] count,
    output logic        expire
);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

    assign expire = (count == (TIMEOUT_CYCLES - 32'd1));

endmodule

// File: rtl/cnna_sram_sched.sv
// Arbitrates the shared SRAM between the UDP loader and the CNN accelerator by run phase.
// Latency: grants/mem strobes combinational; read data returns 1 cycle after a granted read.
// Backpressure: non-owner strobes are simply denied (gnt=0); CNNA_SRAM_SCHED_STATS_EN counts them.
module cnna_sram_sched
    import cnna_sram_sched_pkg::*;
#(
    parameter int          ADDR_W         = ADDR_W_DEF,
    parameter int          UDP_WR_W       = UDP_WR_W_DEF,
    parameter int          WIDE_W         = WIDE_W_DEF,
    parameter int          CNNA_RD_W      = CNNA_RD_W_DEF,
    parameter logic [31:0] TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 udp_rd_en_i,
    input  logic                 udp_wr_en_i,
    input  logic [ADDR_W-1:0]    udp_addr_i,
    input  logic [UDP_WR_W-1:0]  udp_wdata_i,
    output logic                 udp_gnt_o,
    output logic [WIDE_W-1:0]    udp_rdata_o,
    output logic                 udp_rvalid_o,
    input  logic                 cnna_rd_en_i,
    input  logic                 cnna_wr_en_i,
    input  logic [ADDR_W-1:0]    cnna_addr_i,
    input  logic [WIDE_W-1:0]    cnna_wdata_i,
    output logic                 cnna_gnt_o,
    output logic [CNNA_RD_W-1:0] cnna_rdata_o,
    output logic                 cnna_rvalid_o,
    input  logic                 start_i,
    output logic                 cnna_start_o,
    input  logic                 cnna_finish_i,
    output logic                 finish_o,
    output logic                 timeout_o,
    output logic [31:0]          run_cycles_o,
    output logic [15:0]          blocked_cnt_o,
    output logic                 mem_rd_en_o,
    output logic                 mem_wr_en_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [WIDE_W-1:0]    mem_wdata_o,
    output logic                 mem_wide_o,
    input  logic [WIDE_W-1:0]    mem_rdata_i
);

    sched_state_t state, state_nxt;

    logic   udp_req, cnna_req;
    logic   udp_gnt, cnna_gnt;
    logic   timer_clear, timer_en, timer_expire;
    logic   done_set, timeout_set;
    logic   rd_pend;
    owner_t rd_owner;

    assign udp_req  = udp_rd_en_i | udp_wr_en_i;
    assign cnna_req = cnna_rd_en_i | cnna_wr_en_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state <= UDP_OWN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        udp_gnt      = 1'b0;
        cnna_gnt     = 1'b0;
        cnna_start_o = 1'b0;
        timer_clear  = 1'b0;
        timer_en     = 1'b0;
        done_set     = 1'b0;
        timeout_set  = 1'b0;
        case (state)
            UDP_OWN: begin
                udp_gnt = udp_req;
                if (start_i) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                cnna_start_o = 1'b1;
                timer_clear  = 1'b1;
                state_nxt    = CNNA_RUN;
            end
            CNNA_RUN: begin
                cnna_gnt = cnna_req;
                timer_en = 1'b1;
                // A real finish always beats the watchdog in the same cycle.
                if (cnna_finish_i) begin
                    done_set  = 1'b1;
                    state_nxt = DONE;
                end else if (timer_expire) begin
                    done_set    = 1'b1;
                    timeout_set = 1'b1;
                    state_nxt   = DONE;
                end
            end
            DONE: begin
                state_nxt = UDP_OWN;
            end
            default: begin
                state_nxt = UDP_OWN;
            end
        endcase
    end

    assign udp_gnt_o  = udp_gnt;
    assign cnna_gnt_o = cnna_gnt;
    assign mem_wide_o = (state == CNNA_RUN);

    cnna_run_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_run_timer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear     (timer_clear),
        .en        (timer_en),
        .count     (run_cycles_o),
        .expire    (timer_expire)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            finish_o  <= 1'b0;
            timeout_o <= 1'b0;
        end else if (state == LAUNCH) begin
            finish_o  <= 1'b0;
            timeout_o <= 1'b0;
        end else if (done_set) begin
            finish_o  <= 1'b1;
            timeout_o <= timeout_set;
        end
    end

    always_comb begin
        mem_rd_en_o = 1'b0;
        mem_wr_en_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (udp_gnt) begin
            mem_wr_en_o = udp_wr_en_i;
            mem_rd_en_o = udp_rd_en_i & ~udp_wr_en_i;
            mem_addr_o  = udp_addr_i;
            mem_wdata_o = {{(WIDE_W-UDP_WR_W){1'b0}}, udp_wdata_i};
        end else if (cnna_gnt) begin
            mem_wr_en_o = cnna_wr_en_i;
            mem_rd_en_o = cnna_rd_en_i & ~cnna_wr_en_i;
            mem_addr_o  = cnna_addr_i;
            mem_wdata_o = cnna_wdata_i;
        end
    end

    // Return routing follows the owner at grant time, not the current state.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rd_pend  <= 1'b0;
            rd_owner <= OWN_UDP;
        end else begin
            rd_pend  <= mem_rd_en_o;
            rd_owner <= cnna_gnt ? OWN_CNNA : OWN_UDP;
        end
    end

    assign udp_rvalid_o  = rd_pend && (rd_owner == OWN_UDP);
    assign cnna_rvalid_o = rd_pend && (rd_owner == OWN_CNNA);
    assign udp_rdata_o   = udp_rvalid_o  ? mem_rdata_i : '0;
    assign cnna_rdata_o  = cnna_rvalid_o ? mem_rdata_i[CNNA_RD_W-1:0] : '0;

`ifdef CNNA_SRAM_SCHED_STATS_EN
    logic        blocked_hit;
    logic [15:0] blocked_q;

    always_comb begin
        blocked_hit = udp_req | cnna_req;
        case (state)
            UDP_OWN:  blocked_hit = cnna_req;
            CNNA_RUN: blocked_hit = udp_req;
            default:  blocked_hit = udp_req | cnna_req;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            blocked_q <= '0;
        end else if (blocked_hit && (blocked_q != 16'hFFFF)) begin
            blocked_q <= blocked_q + 16'd1;
        end
    end

    assign blocked_cnt_o = blocked_q;
`else
    assign blocked_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cnna_sram_sched.sv
// Randomized and directed bench for cnna_sram_sched against a phase-level reference model.
module tb_cnna_sram_sched;

    localparam logic [31:0] TO = 32'd120;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         urd, uwr, crd, cwr, start, cfin;
    logic [7:0]   uaddr, caddr;
    logic [127:0] uwdata;
    logic [511:0] cwdata, mrdata;

    logic         udp_gnt_o, udp_rvalid_o, cnna_gnt_o, cnna_rvalid_o;
    logic [511:0] udp_rdata_o;
    logic [127:0] cnna_rdata_o;
    logic         cnna_start_o, finish_o, timeout_o;
    logic [31:0]  run_cycles_o;
    logic [15:0]  blocked_cnt_o;
    logic         mem_rd_en_o, mem_wr_en_o, mem_wide_o;
    logic [7:0]   mem_addr_o;
    logic [511:0] mem_wdata_o;

    cnna_sram_sched #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .udp_rd_en_i(urd), .udp_wr_en_i(uwr), .udp_addr_i(uaddr), .udp_wdata_i(uwdata),
        .udp_gnt_o(udp_gnt_o), .udp_rdata_o(udp_rdata_o), .udp_rvalid_o(udp_rvalid_o),
        .cnna_rd_en_i(crd), .cnna_wr_en_i(cwr), .cnna_addr_i(caddr), .cnna_wdata_i(cwdata),
        .cnna_gnt_o(cnna_gnt_o), .cnna_rdata_o(cnna_rdata_o), .cnna_rvalid_o(cnna_rvalid_o),
        .start_i(start), .cnna_start_o(cnna_start_o), .cnna_finish_i(cfin),
        .finish_o(finish_o), .timeout_o(timeout_o), .run_cycles_o(run_cycles_o),
        .blocked_cnt_o(blocked_cnt_o),
        .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wide_o(mem_wide_o), .mem_rdata_i(mrdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: phase 0=UDP owns, 1=launch, 2=accelerator runs, 3=done.
    int          m_ph;
    logic [31:0] m_cnt;
    logic        m_fin, m_to, m_pu, m_pc;
    logic [15:0] m_blk;

    function automatic logic [511:0] rand_wide();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic idle();
        urd = 0; uwr = 0; crd = 0; cwr = 0; start = 0; cfin = 0;
    endtask

    task automatic rand_data();
        logic [511:0] w;
        w = rand_wide();
        uwdata = w[127:0];
        cwdata = rand_wide();
        mrdata = rand_wide();
        uaddr  = 8'($urandom);
        caddr  = 8'($urandom);
    endtask

    task automatic step();
        logic         ug, cg, ureq, creq, blk_hit;
        logic [511:0] e_wd;
        logic [7:0]   e_ad;
        @(negedge clk);
        ureq = urd | uwr;
        creq = crd | cwr;
        ug = (m_ph == 0) && ureq;
        cg = (m_ph == 2) && creq;
        e_ad = ug ? uaddr : (cg ? caddr : 8'h0);
        e_wd = ug ? {384'b0, uwdata} : (cg ? cwdata : 512'b0);
        chk("udp_gnt", udp_gnt_o, ug);
        chk("cnna_gnt", cnna_gnt_o, cg);
        chk("mem_wr", mem_wr_en_o, (ug && uwr) || (cg && cwr));
        chk("mem_rd", mem_rd_en_o, (ug && urd && !uwr) || (cg && crd && !cwr));
        chk("mem_addr", mem_addr_o, e_ad);
        chk("mem_wdata", mem_wdata_o, e_wd);
        chk("mem_wide", mem_wide_o, m_ph == 2);
        chk("cnna_start", cnna_start_o, m_ph == 1);
        chk("finish", finish_o, m_fin);
        chk("timeout", timeout_o, m_to);
        chk("run_cycles", run_cycles_o, m_cnt);
        chk("blocked", blocked_cnt_o, m_blk);
        chk("udp_rvalid", udp_rvalid_o, m_pu);
        chk("udp_rdata", udp_rdata_o, m_pu ? mrdata : 512'b0);
        chk("cnna_rvalid", cnna_rvalid_o, m_pc);
        chk("cnna_rdata", cnna_rdata_o, m_pc ? mrdata[127:0] : 128'b0);
        @(posedge clk);
        if (!rst_n) begin
            m_ph = 0; m_cnt = 0; m_fin = 0; m_to = 0; m_pu = 0; m_pc = 0; m_blk = 0;
        end else begin
            m_pu = ug && urd && !uwr;
            m_pc = cg && crd && !cwr;
            blk_hit = (m_ph == 0) ? creq : ((m_ph == 2) ? ureq : (ureq | creq));
`ifdef CNNA_SRAM_SCHED_STATS_EN
            if (blk_hit && m_blk != 16'hFFFF) m_blk = m_blk + 16'd1;
`endif
            case (m_ph)
                0: if (start) m_ph = 1;
                1: begin m_cnt = 0; m_fin = 0; m_to = 0; m_ph = 2; end
                2: begin
                    if (cfin) begin
                        m_fin = 1; m_to = 0; m_ph = 3;
                    end else if (m_cnt == TO - 1) begin
                        m_fin = 1; m_to = 1; m_ph = 3;
                    end
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                end
                default: m_ph = 0;
            endcase
        end
        #1;
    endtask

    logic [15:0] blk_snap;

    initial begin
        m_ph = 0; m_cnt = 0; m_fin = 0; m_to = 0; m_pu = 0; m_pc = 0; m_blk = 0;
        rst_n = 0; idle(); rand_data();
        uaddr = 0; caddr = 0; uwdata = 0; cwdata = 0;
        repeat (2) step();
        rst_n = 1;
        #1;
        chk("rst_finish", finish_o, 0);
        chk("rst_runcyc", run_cycles_o, 0);
        chk("rst_wide", mem_wide_o, 0);

        // UDP write while the accelerator also tries to read
        uwr = 1; uaddr = 8'h05; uwdata = 128'hA5; crd = 1;
        #1;
        chk("wr_gnt", udp_gnt_o, 1);
        chk("wr_mem_wr", mem_wr_en_o, 1);
        chk("wr_wdata", mem_wdata_o, 512'hA5);
        chk("wr_addr", mem_addr_o, 8'h05);
        chk("wr_cnna_gnt", cnna_gnt_o, 0);
        step();
        idle();

        // start accepted together with a UDP read; read returns during launch
        start = 1; urd = 1; uaddr = 8'h07;
        step();
        idle(); mrdata = rand_wide();
        #1;
        chk("launch_pulse", cnna_start_o, 1);
        chk("launch_rvalid", udp_rvalid_o, 1);
        chk("launch_rdata", udp_rdata_o, mrdata);
        step();
        repeat (99) begin rand_data(); step(); end
        cfin = 1; step(); idle();
        chk("run100_finish", finish_o, 1);
        chk("run100_cycles", run_cycles_o, 100);
        chk("run100_timeout", timeout_o, 0);
        step();
        urd = 1; #1;
        chk("back_udp_gnt", udp_gnt_o, 1);
        step(); idle();

        // watchdog abort, with UDP strobing during the run
        start = 1; step(); idle();
        step();
        chk("to_pre_fin", finish_o, 0);
        blk_snap = m_blk;
        for (int i = 0; i < int'(TO); i++) begin
            urd = (i < 5); step();
        end
        idle();
        chk("to_timeout", timeout_o, 1);
        chk("to_finish", finish_o, 1);
        chk("to_cycles", run_cycles_o, TO);
`ifdef CNNA_SRAM_SCHED_STATS_EN
        chk("blk_five", blocked_cnt_o, blk_snap + 16'd5);
`else
        chk("blk_zero", blocked_cnt_o, 16'd0);
`endif
        step();
        start = 1; step(); idle(); step();
        chk("clr_timeout", timeout_o, 0);
        chk("clr_finish", finish_o, 0);

        // reset during a run with a CNNA read in flight
        crd = 1; caddr = 8'h33;
        repeat (3) step();
        rst_n = 0; step();
        rst_n = 1; idle(); #1;
        chk("rstrun_rvalid", cnna_rvalid_o, 0);
        chk("rstrun_runcyc", run_cycles_o, 0);
        chk("rstrun_wide", mem_wide_o, 0);
        chk("rstrun_start", cnna_start_o, 0);
        chk("rstrun_blk", blocked_cnt_o, 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rand_data();
            rst_n = ($urandom_range(0, 499) != 0);
            urd   = ($urandom_range(0, 2) == 0);
            uwr   = ($urandom_range(0, 3) == 0);
            crd   = ($urandom_range(0, 2) == 0);
            cwr   = ($urandom_range(0, 3) == 0);
            start = ($urandom_range(0, 19) == 0);
            cfin  = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
